// File: rtl/aqfp_pkg.sv
// Shared helpers for the AQFP behavioural models: phase index sizing,
// inverter-mask parity and a population count.
package aqfp_pkg;

    localparam int unsigned AQFP_MAX_DEPTH = 64;

    function automatic int unsigned phase_w(input int unsigned nphase);
        return (nphase < 2) ? 1 : $clog2(nphase);
    endfunction

    // Net polarity of a token after traversing every stage of a chain.
    function automatic logic mask_parity(input logic [AQFP_MAX_DEPTH-1:0] mask);
        return ^mask;
    endfunction

    function automatic int unsigned popcount(input logic [AQFP_MAX_DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < AQFP_MAX_DEPTH; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/aqfp_phase_pipe_if.sv
// Token input/output bundle of the AQFP phase pipeline.
interface aqfp_phase_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/aqfp_stage.sv
// One AQFP buffer/inverter stage: data plus valid, captured on its excitation phase.
module aqfp_stage #(
    parameter int WIDTH = 8,
    parameter bit INV   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cap,
    input  logic             i_clr,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_valid_nxt
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Flush wins over capture; i_clr retires the token once it has moved on.
    always_comb begin
        o_valid_nxt = r_valid;
        if (i_flush) begin
            o_valid_nxt = 1'b0;
        end else if (i_cap) begin
            o_valid_nxt = i_valid;
        end else if (i_clr) begin
            o_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= o_valid_nxt;
            if (i_cap) begin
                r_data <= i_data ^ {WIDTH{INV}};
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/aqfp_phase_pipe.sv
// Path-balanced AQFP buffer/inverter chain clocked by an NPHASE excitation
// counter; stage k captures when phase == k mod NPHASE.
module aqfp_phase_pipe
    import aqfp_pkg::*;
#(
    parameter int             WIDTH    = 8,
    parameter int             DEPTH    = 6,
    parameter int             NPHASE   = 4,
    parameter logic [DEPTH-1:0] INV_MASK = {DEPTH{1'b0}},
    localparam int            PW       = phase_w(NPHASE),
    localparam int            IW       = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 flush,
    aqfp_phase_pipe_if.slave     bus,
    output logic [PW-1:0]        phase,
    output logic [IW-1:0]        inflight
);
    logic [PW-1:0]    r_phase;
    logic [IW-1:0]    r_inflight;
    logic             w_accept;
    logic [WIDTH-1:0] w_data [DEPTH+1];
    logic [DEPTH:0]   w_valid;
    logic [DEPTH-1:0] w_cap;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_valid_nxt;

    assign bus.in_ready = en && !flush && (r_phase == '0);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_data[0]    = bus.in_data;
    assign w_valid[0]   = w_accept;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        localparam int unsigned PH = k % NPHASE;

        assign w_cap[k] = en && (r_phase == PW'(PH));

        // A token leaves stage k when stage k+1 copies it; the last stage
        // holds its token for exactly one cycle so out_valid is a pulse.
        if (k == DEPTH - 1) begin : g_last
            assign w_clr[k] = 1'b1;
        end else begin : g_mid
            assign w_clr[k] = w_cap[k+1];
        end

        aqfp_stage #(
            .WIDTH (WIDTH),
            .INV   (INV_MASK[k])
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_cap       (w_cap[k]),
            .i_clr       (w_clr[k]),
            .i_flush     (flush),
            .i_data      (w_data[k]),
            .i_valid     (w_valid[k]),
            .o_data      (w_data[k+1]),
            .o_valid     (w_valid[k+1]),
            .o_valid_nxt (w_valid_nxt[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_inflight <= '0;
        end else begin
            if (en) begin
                r_phase <= (r_phase == PW'(NPHASE - 1)) ? '0 : r_phase + PW'(1);
            end
            r_inflight <= IW'(popcount(64'(w_valid_nxt)));
        end
    end

    assign bus.out_data  = w_data[DEPTH];
    assign bus.out_valid = w_valid[DEPTH];
    assign phase         = r_phase;
    assign inflight      = r_inflight;
endmodule

// File: tb/tb_aqfp_phase_pipe.sv
// Bench for aqfp_phase_pipe: two chains with different inverter masks share
// one stimulus and are checked against a token-position reference model.
module tb_aqfp_phase_pipe;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 6;
    localparam int NPHASE = 4;
    localparam logic [DEPTH-1:0] MASK_A = 6'b000011;
    localparam logic [DEPTH-1:0] MASK_B = 6'b000001;
    localparam logic PAR_A = ^MASK_A;
    localparam logic PAR_B = ^MASK_B;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       phase_a, phase_b;
    logic [2:0]       infl_a, infl_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: each token is a (data, stage position) pair.
    logic [WIDTH-1:0] q_data[$];
    int               q_pos[$];
    int               m_phase = 0;
    logic             m_ov = 1'b0;
    logic [WIDTH-1:0] m_od = '0;
    bit               m_acc = 1'b0;

    aqfp_phase_pipe_if #(.WIDTH(WIDTH)) bus_a ();
    aqfp_phase_pipe_if #(.WIDTH(WIDTH)) bus_b ();

    assign bus_a.in_data  = in_data;
    assign bus_a.in_valid = in_valid;
    assign bus_b.in_data  = in_data;
    assign bus_b.in_valid = in_valid;

    aqfp_phase_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NPHASE(NPHASE), .INV_MASK(MASK_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .bus(bus_a.slave), .phase(phase_a), .inflight(infl_a)
    );
    aqfp_phase_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NPHASE(NPHASE), .INV_MASK(MASK_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .bus(bus_b.slave), .phase(phase_b), .inflight(infl_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_pos.delete();
        m_phase = 0;
        m_ov = 1'b0;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] nd[$];
        int               np[$];
        m_acc = en && !flush && (m_phase == 0) && in_valid;
        m_ov = 1'b0;
        for (int i = 0; i < q_pos.size(); i++) begin
            if (flush || q_pos[i] == DEPTH - 1) continue;
            np.push_back(en ? q_pos[i] + 1 : q_pos[i]);
            nd.push_back(q_data[i]);
            if (np[np.size()-1] == DEPTH - 1) begin
                m_ov = 1'b1;
                m_od = q_data[i];
            end
        end
        if (m_acc) begin
            np.push_back(0);
            nd.push_back(in_data);
        end
        q_pos = np;
        q_data = nd;
        if (en) m_phase = (m_phase + 1) % NPHASE;
    endtask

    task automatic check_all();
        chk("phase_a", phase_a, m_phase);
        chk("phase_b", phase_b, m_phase);
        chk("inflight_a", infl_a, q_pos.size());
        chk("inflight_b", infl_b, q_pos.size());
        chk("out_valid_a", bus_a.out_valid, m_ov);
        chk("out_valid_b", bus_b.out_valid, m_ov);
        if (m_ov) begin
            chk("out_data_a", bus_a.out_data, m_od ^ {WIDTH{PAR_A}});
            chk("out_data_b", bus_b.out_data, m_od ^ {WIDTH{PAR_B}});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_phase"}, phase_a, 0);
        chk({tag, "_inflight"}, infl_a, 0);
        chk({tag, "_out_valid"}, bus_a.out_valid, 0);
        chk({tag, "_out_data_a"}, bus_a.out_data, 0);
        chk({tag, "_out_data_b"}, bus_b.out_data, 0);
    endtask

    task automatic tick();
        #1;
        chk("in_ready_a", bus_a.in_ready, en && !flush && (m_phase == 0));
        chk("in_ready_b", bus_b.in_ready, en && !flush && (m_phase == 0));
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic to_phase0();
        for (int i = 0; i < 2 * NPHASE && m_phase != 0; i++) tick();
        chk("to_phase0", m_phase, 0);
    endtask

    task automatic single_token(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_a,
                                input logic [WIDTH-1:0] exp_b, input string tag);
        to_phase0();
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= DEPTH - 1; i++) begin
            tick();
            if (i < DEPTH - 1) chk({tag, "_early"}, bus_a.out_valid, 0);
        end
        chk({tag, "_ov"}, bus_a.out_valid, 1);
        chk({tag, "_data_a"}, bus_a.out_data, exp_a);
        chk({tag, "_data_b"}, bus_b.out_data, exp_b);
        tick();
        chk({tag, "_ov_clear"}, bus_a.out_valid, 0);
        chk({tag, "_drained"}, infl_a, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] toks[3];
        logic [WIDTH-1:0] outs[$];
        int               out_cyc[$];
        int               acc_cyc[$];
        int               peak, idx, t0, ph, inf, pulses;
        bit               rdy;

        // Reset state and phase sequence
        #12;
        check_zero("reset");
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("phase_seq", phase_a, i % NPHASE);
        end

        // Passthrough latency and inversion
        single_token(8'hA5, 8'hA5, 8'h5A, "lat");
        single_token(8'h3C, 8'h3C, 8'hC3, "inv");

        // Back-to-back tokens under a held in_valid
        toks[0] = 8'h01; toks[1] = 8'h02; toks[2] = 8'h03;
        to_phase0();
        idx = 0;
        peak = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = toks[idx < 3 ? idx : 2];
            #1;
            rdy = bus_a.in_ready;
            tick();
            if (rdy && in_valid) begin
                acc_cyc.push_back(cyc);
                idx++;
                if (idx == 3) in_valid = 1'b0;
            end
            if (int'(infl_a) > peak) peak = int'(infl_a);
            if (bus_a.out_valid) begin
                outs.push_back(bus_a.out_data);
                out_cyc.push_back(cyc);
            end
        end
        chk("b2b_peak", peak, 2);
        chk("b2b_accepts", acc_cyc.size(), 3);
        chk("b2b_outputs", outs.size(), 3);
        for (int i = 0; i < 3 && i < outs.size(); i++) chk("b2b_order", outs[i], toks[i]);
        for (int i = 1; i < 3 && i < out_cyc.size(); i++) chk("b2b_out_gap", out_cyc[i] - out_cyc[i-1], NPHASE);
        for (int i = 1; i < 3 && i < acc_cyc.size(); i++) chk("b2b_acc_gap", acc_cyc[i] - acc_cyc[i-1], NPHASE);

        // Stall while a token sits in stage 2
        to_phase0();
        in_valid = 1'b1;
        in_data = 8'h77;
        tick();
        t0 = cyc;
        in_valid = 1'b0;
        tick();
        tick();
        ph = int'(phase_a);
        inf = int'(infl_a);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_phase", phase_a, ph);
            chk("stall_inflight", infl_a, inf);
        end
        en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12 && pulses == 0; i++) begin
            tick();
            if (bus_a.out_valid) begin
                pulses++;
                chk("stall_latency", cyc - t0, DEPTH - 1 + 3);
                chk("stall_data", bus_a.out_data, 8'h77);
            end
        end
        chk("stall_pulse_seen", pulses, 1);

        // Flush with two tokens in flight
        to_phase0();
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_valid = 1'b0; tick(); tick(); tick();
        in_valid = 1'b1; in_data = 8'h22; tick();
        in_valid = 1'b0;
        chk("flush_pre_inflight", infl_a, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_inflight", infl_a, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(bus_a.out_valid);
        end
        chk("flush_no_pulse", pulses, 0);

        // Flush at phase 0 beats a simultaneous in_valid
        to_phase0();
        in_valid = 1'b1; in_data = 8'h33; tick();
        in_valid = 1'b0; tick(); tick(); tick();
        in_valid = 1'b1; in_data = 8'h34; flush = 1'b1;
        #1;
        chk("flush_ready", bus_a.in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush0_inflight", infl_a, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(bus_a.out_valid);
        end
        chk("flush0_no_pulse", pulses, 0);

        // Flush while excitation is disabled
        to_phase0();
        in_valid = 1'b1; in_data = 8'h55; tick();
        in_valid = 1'b0; tick();
        ph = int'(phase_a);
        en = 1'b0; flush = 1'b1;
        tick();
        chk("flush_en0_phase", phase_a, ph);
        chk("flush_en0_inflight", infl_a, 0);
        en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Asynchronous reset with a token in flight
        to_phase0();
        in_valid = 1'b1; in_data = 8'h44; tick();
        in_valid = 1'b0; tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h66;
        tick();
        in_valid = 1'b0;
        chk("post_reset_accept", infl_a, 1);
        for (int i = 0; i < 10; i++) tick();

        // Randomised traffic with valid/ready source behaviour
        for (int i = 0; i < 400; i++) begin
            if (!in_valid) begin
                in_valid = ($urandom % 2) == 0;
                in_data = WIDTH'($urandom);
            end
            en = ($urandom % 10) != 0;
            flush = ($urandom % 25) == 0;
            tick();
            if (m_acc) in_valid = 1'b0;
        end
        en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) tick();
        chk("final_drained", infl_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
